// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling stage: walks s_RAM once, j += s[i] + key[i mod KEY_BYTES],
// swaps s[i]/s[j], then pulses stop for one cycle.
// Ports: clock, reset (sync, active-high), start, secret_key (byte 0 = MSB),
//        q (RAM read data), address/data/wren (RAM bus), stop (done pulse).
// Option: define KSA_SKIP_SELF_SWAP_EN to skip both writes when i == j.
module ksa_swap_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  output logic                   stop
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ_I,
    S_WAIT_I,
    S_CALC_J,
    S_READ_J,
    S_WAIT_J,
    S_LATCH_J,
    S_WRITE_I,
    S_WRITE_J,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_i;
  logic [7:0]    r_j;
  logic [7:0]    r_si;
  logic [7:0]    r_sj;
  logic [KW-1:0] r_k;
  logic [7:0]    w_key;

  // Key byte k, counted from the MSB end of secret_key.
  always_comb begin
    w_key = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (r_k == KW'(b)) begin
        w_key = secret_key[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_i  <= '0;
      r_j  <= '0;
      r_k  <= '0;
      r_si <= '0;
      r_sj <= '0;
    end else begin
      case (r_state)
        S_CALC_J: begin
          r_si <= q;
          r_j  <= r_j + q + w_key;
        end
        S_LATCH_J: begin
          r_sj <= q;
        end
        S_NEXT: begin
          if (r_i != 8'hFF) begin
            r_i <= r_i + 8'd1;
            r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
          end
        end
        S_DONE: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_READ_I;
      S_READ_I:  w_next = S_WAIT_I;
      S_WAIT_I:  w_next = S_CALC_J;
      S_CALC_J:  w_next = S_READ_J;
      S_READ_J:  w_next = S_WAIT_J;
      S_WAIT_J:  w_next = S_LATCH_J;
`ifdef KSA_SKIP_SELF_SWAP_EN
      // A self-swap leaves the RAM unchanged, so both writes are dropped.
      S_LATCH_J: w_next = (r_i == r_j) ? S_NEXT : S_WRITE_I;
`else
      S_LATCH_J: w_next = S_WRITE_I;
`endif
      S_WRITE_I: w_next = S_WRITE_J;
      S_WRITE_J: w_next = S_NEXT;
      S_NEXT:    w_next = (r_i == 8'hFF) ? S_DONE : S_READ_I;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    stop    = 1'b0;
    case (r_state)
      S_READ_I,
      S_WAIT_I:  address = r_i;
      S_READ_J,
      S_WAIT_J:  address = r_j;
      S_WRITE_I: begin
        address = r_i;
        data    = r_sj;
        wren    = 1'b1;
      end
      S_WRITE_J: begin
        address = r_j;
        data    = r_si;
        wren    = 1'b1;
      end
      S_DONE:    stop = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Self-checking bench for ksa_swap_fsm: vector table for first-iteration bus
// activity plus full runs compared against a software RC4 KSA model.
module tb_ksa_swap_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        stop;

  always #5 clock = ~clock;

  ksa_swap_fsm #(.KEY_BYTES(3)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .secret_key(secret_key),
    .q(q),
    .address(address),
    .data(data),
    .wren(wren),
    .stop(stop)
  );

`ifdef KSA_SKIP_SELF_SWAP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Single-port synchronous RAM, one-cycle read latency.
  logic [7:0] mem [256];
  logic       pre_en = 1'b0;

  always @(posedge clock) begin
    if (pre_en) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference RC4 KSA on plain integers.
  int m_s [256];
  int m_lat;
  int m_self;
  int ew_a [$];
  int ew_d [$];

  function automatic void model(input logic [23:0] key);
    int kb [3];
    int j;
    int t;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    ew_a.delete();
    ew_d.delete();
    m_self = 0;
    j = 0;
    for (int i = 0; i < 256; i++) m_s[i] = i;
    for (int i = 0; i < 256; i++) begin
      j = (j + m_s[i] + kb[i % 3]) % 256;
      if (i == j) m_self++;
      if (!(SKIP && i == j)) begin
        ew_a.push_back(i);
        ew_d.push_back(m_s[j]);
        ew_a.push_back(j);
        ew_d.push_back(m_s[i]);
      end
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
    end
    m_lat = 256 * 9 + 1 - (SKIP ? 2 * m_self : 0);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic preload;
    pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  // Full run from a preloaded idle block. pa: extra start pulse cycle,
  // pdone: pulse start during DONE, hold: keep start high from DONE on.
  task automatic run_body(input logic [23:0] key, input int pa,
                          input bit pdone, input bit hold,
                          input string name);
    int ga [$];
    int gd [$];
    int nst;
    int stc;
    int bad;
    int j2;
    int wtr [10];
    int ew;
    model(key);
    secret_key = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    nst = 0;
    stc = 0;
    for (int i = 0; i < 10; i++) wtr[i] = -1;
    for (int cyc = 1; cyc <= 2330; cyc++) begin
      if (wren && (!hold || cyc <= m_lat)) begin
        ga.push_back(int'(address));
        gd.push_back(int'(data));
      end
      if (stop) begin
        nst++;
        stc = cyc;
      end
      if (cyc == m_lat + 1) begin
        bad = -1;
        for (int a = 0; a < 256; a++)
          if (bad < 0 && int'(mem[a]) != m_s[a]) bad = a;
        chk($sformatf("%s ram first bad addr", name), bad, -1);
      end
      if (cyc >= m_lat + 2 && cyc <= m_lat + 11)
        wtr[cyc - m_lat - 2] = int'(wren);
      start = (cyc == pa) || (pdone && cyc == m_lat) ||
              (hold && cyc >= m_lat);
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s stop count", name), nst, 1);
    chk($sformatf("%s stop cycle", name), stc, m_lat);
    chk($sformatf("%s write count", name), ga.size(), ew_a.size());
    bad = -1;
    for (int n = 0; n < ga.size() && n < ew_a.size(); n++)
      if (bad < 0 && (ga[n] != ew_a[n] || gd[n] != ew_d[n])) bad = n;
    chk($sformatf("%s first bad write", name), bad, -1);
    if (hold) begin
      j2 = (m_s[0] + int'(key[23:16])) % 256;
      bad = -1;
      for (int o = 0; o < 10; o++) begin
        ew = ((o == 6 || o == 7) && !(SKIP && j2 == 0)) ? 1 : 0;
        if (bad < 0 && wtr[o] != ew) bad = o;
      end
      chk($sformatf("%s restart wren trace bad offset", name), bad, -1);
    end
  endtask

  typedef struct {
    logic [23:0] key;
    int          cyc;
    int          wren;
    int          addr;
    int          data;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{24'h010203,  1, 0,   0,   0};
    vt[1] = '{24'h010203,  4, 0,   1,   0};
    vt[2] = '{24'h010203,  7, 1,   0,   1};
    vt[3] = '{24'h010203,  8, 1,   1,   0};
    vt[4] = '{24'h010203, 10, 0,   1,   0};
    vt[5] = '{24'hFFFFFF,  7, 1,   0, 255};
    vt[6] = '{24'hFFFFFF,  8, 1, 255,   0};
    vt[7] = '{24'h050000,  5, 0,   5,   0};
    vt[8] = '{24'h050000, 16, 1,   1,   6};
    vt[9] = '{24'h050000, 17, 1,   6,   1};

    do_reset();
    chk("reset address", int'(address), 0);
    chk("reset data", int'(data), 0);
    chk("reset wren", int'(wren), 0);
    chk("reset stop", int'(stop), 0);

    for (int n = 0; n < 10; n++) begin
      do_reset();
      preload();
      secret_key = vt[n].key;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (vt[n].cyc - 1) tick();
      chk($sformatf("vec%0d wren", n), int'(wren), vt[n].wren);
      chk($sformatf("vec%0d address", n), int'(address), vt[n].addr);
      chk($sformatf("vec%0d data", n), int'(data), vt[n].data);
    end

    do_reset();
    preload();
    run_body(24'h000311, 0, 1'b0, 1'b0, "full311");

    do_reset();
    preload();
    run_body(24'h010203, 50, 1'b1, 1'b0, "ignored_starts");

    do_reset();
    preload();
    run_body(24'h010203, 0, 1'b0, 1'b1, "held_start");

    do_reset();
    preload();
    secret_key = 24'h000311;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset wren", int'(wren), 0);
    chk("midreset address", int'(address), 0);
    chk("midreset stop", int'(stop), 0);
    repeat (5) tick();
    chk("midreset stays idle wren", int'(wren), 0);
    preload();
    run_body(24'h000311, 0, 1'b0, 1'b0, "after_reset");

    do_reset();
    preload();
    run_body(24'h000000, 0, 1'b0, 1'b0, "selfswap");

    do_reset();
    preload();
    run_body(24'hFFFFFF, 0, 1'b0, 1'b0, "wrap");

    for (int r = 0; r < 3; r++) begin
      logic [23:0] rk;
      rk = 24'($urandom);
      do_reset();
      preload();
      run_body(rk, 0, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ksa_swap_fsm.md
Name: ksa_swap_fsm

Overview:
- Second stage of the RC4 pipeline. It runs after the S-array initializer has filled s_RAM with s[i]=i.
- Performs the key-scheduling pass over s_RAM: for i=0..255, j = j + s[i] + key[i mod KEY_BYTES], then swap s[i] and s[j].
- Drives the single-port s_RAM address/data/wren bus directly. The top-level mux hands it the bus after the initializer's stop pulse.
- Signals completion with a one-cycle stop pulse to the downstream decrypt stage.

Parameters:
- KEY_BYTES, 3: number of secret-key bytes. The key port is 8*KEY_BYTES bits wide.

Ports:
- clock, input, 1: sole clock, rising-edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: level; sampled only in IDLE.
- secret_key, input, 8*KEY_BYTES: key byte 0 = secret_key[8*KEY_BYTES-1 -: 8] (MSB first). Must be stable from start until stop.
- q, input, 8: s_RAM read data.
- address, output, 8: s_RAM address.
- data, output, 8: s_RAM write data.
- wren, output, 1: s_RAM write enable.
- stop, output, 1: one-cycle done pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- s_RAM read latency: an address driven in cycle N produces valid q in cycle N+1. The block holds the address one extra (wait) cycle before sampling q.
- Reset: state=IDLE; i=0, j=0, key index k=0, si_reg=0, sj_reg=0. Outputs: address=0, data=0, wren=0, stop=0. Reset mid-run aborts immediately, with no partial write in the following cycle.
- Internal registers:
  - i, j: 8-bit; all arithmetic is modulo 256 with natural wrap.
  - k: counts 0..KEY_BYTES-1 and wraps alongside i. No divider is used.
- States and transitions (one cycle each unless noted):
  - IDLE: wren=0. If start, go to READ_I; otherwise stay.
  - READ_I: address=i.
  - WAIT_I: address=i.
  - CALC_J: si_reg<=q; j<=j+q+key[k].
  - READ_J: address=j.
  - WAIT_J: address=j.
  - LATCH_J: sj_reg<=q.
  - WRITE_I: address=i, data=sj_reg, wren=1.
  - WRITE_J: address=j, data=si_reg, wren=1.
  - NEXT: if i==255, go to DONE. Otherwise i<=i+1, k<=(k==KEY_BYTES-1)?0:k+1, and go to READ_I.
  - DONE: stop=1, then IDLE. i, j and k are cleared on the transition to IDLE.
- wren is high only in WRITE_I and WRITE_J. data is don't-care but held at 0 when wren=0.
- Timing: 9 cycles per iteration × 256 iterations. Cycle 1 is the first cycle after the edge that samples start; DONE occupies cycle 2305.
- start asserted outside IDLE is ignored, including during DONE. If start is still high when the block re-enters IDLE, a new run begins.
- i==j (self-swap) without the optional feature: both writes occur, writing the same value to the same address. The RAM is unchanged.
- secret_key changing mid-run: the result is undefined. No checking is done.

Optional Feature:
- Macro: KSA_SKIP_SELF_SWAP_EN.
- Defined: LATCH_J compares i and j. If i==j, it goes straight to NEXT, skipping WRITE_I and WRITE_J, so that iteration takes 7 cycles and wren stays 0. Total latency becomes 2305 − 2×(number of self-swap iterations). The final RAM contents are identical.
- Undefined: fixed 9-cycle iterations and fixed 2305-cycle latency.

Test Plan:
1. First iteration. RAM preloaded s[k]=k, secret_key=24'h010203, pulse start.
   - Cycle 7: wren=1, address=0, data=1.
   - Cycle 8: wren=1, address=1, data=0.
2. Full run. Same preload, key 24'h000311.
   - stop is high for exactly 1 cycle, at cycle 2305.
   - Final 256 RAM bytes match the software RC4 KSA model byte-for-byte.
3. Restart robustness. start pulsed again at cycles 50 and 2305.
   - Both pulses are ignored; no second run occurs.
   - start held high through DONE: a new run begins, and its cycle 1 is the cycle after the IDLE sample.
4. Reset mid-run. reset asserted at cycle 100 for 1 cycle.
   - Next cycle: wren=0, address=0, stop=0.
   - A subsequent start runs the full 2305 cycles from i=0, j=0.
5. Self-swap. Key 24'h000000, preload s[k]=k.
   - Iteration i=1 gives j=1.
   - Macro undefined: two writes of 1 to address 1.
   - Macro defined: no wren in that iteration, and stop arrives 2 cycles earlier per self-swap.
6. Wrap-around. Key 24'hFFFFFF.
   - j=0+0+255=255 in iteration 0; subsequent j values wrap modulo 256.
   - Final RAM matches the model.
